// File: rtl/vga_ctrl_pkg.sv
// Shared definitions for the VGA DDR stream controller: state encoding and pattern type.
package vga_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PREFILL = 2'd1,
    ST_RUN     = 2'd2,
    ST_RECOVER = 2'd3
  } state_t;

  typedef logic [1:0] pattern_t;

  localparam int unsigned FIFO_LVL_W = 4;

  // Pattern selection wraps 3 -> 0.
  function automatic pattern_t pattern_next(input pattern_t p);
    return p + 2'd1;
  endfunction

endpackage

// File: rtl/vga_stream_ctrl_sync2.sv
// Generic two-flop synchronizer with asynchronous active-low reset (resets to 0).
module sync2 (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/vga_stream_ctrl.sv
// Brings up the pattern-gen -> FIFO -> vga_tx_ddr path after PLL lock, pre-fills, recovers from
// underflow, and applies pattern/mono on frame boundaries. Optional: VGA_STREAM_CTRL_UNDERFLOW_CNT_EN.
module vga_stream_ctrl
  import vga_ctrl_pkg::*;
#(
  parameter int unsigned LOCK_WAIT   = 1024,
  parameter int unsigned GEN_RST_CYC = 4,
  parameter int unsigned PREFILL_LVL = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pll_locked,
  input  logic                  btn_next,
  input  logic                  mono_req,
  input  logic [FIFO_LVL_W-1:0] fifo_status,
  input  logic                  frame_start,
  output logic                  gen_rst,
  output logic                  tx_en,
  output logic [1:0]            pattern,
  output logic                  mono,
  output logic [1:0]            state,
  output logic [7:0]            underflow_cnt
);

  localparam int unsigned LCW = $clog2(LOCK_WAIT + 1);
  localparam int unsigned GCW = $clog2(GEN_RST_CYC + 1);
  localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_WAIT - 1);
  localparam logic [LCW-1:0] LOCK_FULL = LCW'(LOCK_WAIT);
  localparam logic [GCW-1:0] GRST_LAST = GCW'(GEN_RST_CYC - 1);
  localparam logic [FIFO_LVL_W-1:0] FILL_LVL = FIFO_LVL_W'(PREFILL_LVL);

  logic           w_lk;
  logic           w_btn_fall;
  logic           w_uf_evt;

  state_t         r_state;
  logic           r_gen_rst;
  logic           r_tx_en;
  logic [LCW-1:0] r_lock_cnt;
  logic [GCW-1:0] r_grst_cnt;
  logic           r_btn_d;
  pattern_t       r_pend_pattern;
  pattern_t       r_pattern;
  logic           r_mono;

  sync2 u_lock_sync (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_d     (pll_locked),
    .o_q     (w_lk)
  );

  assign w_btn_fall = r_btn_d & ~btn_next;
  assign w_uf_evt   = w_lk && (r_state == ST_RUN) && (fifo_status == '0);

  // Lock counter reaches LOCK_WAIT on the same edge the FSM enters PREFILL, then parks there
  // until lock is lost, so the IDLE exit lands exactly LOCK_WAIT cycles after lk rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_gen_rst  <= 1'b1;
      r_tx_en    <= 1'b0;
      r_lock_cnt <= '0;
      r_grst_cnt <= '0;
    end else if (!w_lk) begin
      r_state    <= ST_IDLE;
      r_gen_rst  <= 1'b1;
      r_tx_en    <= 1'b0;
      r_lock_cnt <= '0;
      r_grst_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_gen_rst <= 1'b1;
          r_tx_en   <= 1'b0;
          if (r_lock_cnt == LOCK_LAST) begin
            r_lock_cnt <= LOCK_FULL;
            r_grst_cnt <= '0;
            r_state    <= ST_PREFILL;
          end else begin
            r_lock_cnt <= r_lock_cnt + 1'b1;
          end
        end
        ST_PREFILL: begin
          r_tx_en <= 1'b0;
          if (r_gen_rst) begin
            if (r_grst_cnt == GRST_LAST) begin
              r_gen_rst <= 1'b0;
            end else begin
              r_grst_cnt <= r_grst_cnt + 1'b1;
            end
          end else if (fifo_status >= FILL_LVL) begin
            r_state <= ST_RUN;
            r_tx_en <= 1'b1;
          end
        end
        ST_RUN: begin
          r_gen_rst <= 1'b0;
          r_tx_en   <= 1'b1;
          if (fifo_status == '0) begin
            r_state   <= ST_RECOVER;
            r_tx_en   <= 1'b0;
            r_gen_rst <= 1'b1;
          end
        end
        default: begin
          r_tx_en    <= 1'b0;
          r_gen_rst  <= 1'b1;
          r_grst_cnt <= '0;
          r_state    <= ST_PREFILL;
        end
      endcase
    end
  end

  // Outside RUN the selections track the request every cycle; in RUN only at frame_start,
  // so a press coincident with frame_start is applied at the following frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btn_d        <= 1'b0;
      r_pend_pattern <= '0;
      r_pattern      <= '0;
      r_mono         <= 1'b0;
    end else begin
      r_btn_d <= btn_next;
      if (w_btn_fall) begin
        r_pend_pattern <= pattern_next(r_pend_pattern);
      end
      if ((r_state != ST_RUN) || frame_start) begin
        r_pattern <= r_pend_pattern;
        r_mono    <= mono_req;
      end
    end
  end

`ifdef VGA_STREAM_CTRL_UNDERFLOW_CNT_EN
  logic [7:0] r_uf_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_uf_cnt <= '0;
    end else if (w_uf_evt && (r_uf_cnt != 8'hFF)) begin
      r_uf_cnt <= r_uf_cnt + 8'd1;
    end
  end

  assign underflow_cnt = r_uf_cnt;
`else
  logic w_uf_unused;
  assign w_uf_unused   = w_uf_evt;
  assign underflow_cnt = '0;
`endif

  assign gen_rst = r_gen_rst;
  assign tx_en   = r_tx_en;
  assign pattern = r_pattern;
  assign mono    = r_mono;
  assign state   = r_state;

endmodule
